// File: rtl/sa_tile_scheduler.sv
// Tile-level sequencer: walks an M x N x K tiled product through one systolic array in m->n->k order.
// Optional RUN watchdog enabled by defining SA_SCHED_TIMEOUT_EN.
module sa_tile_scheduler #(
  parameter int TILE_CNT_W  = 8,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic                  I_CLK,
  input  logic                  I_RST_N,
  input  logic                  I_START,
  input  logic [TILE_CNT_W-1:0] I_M_TILES,
  input  logic [TILE_CNT_W-1:0] I_N_TILES,
  input  logic [TILE_CNT_W-1:0] I_K_TILES,
  output logic                  O_BUSY,
  output logic                  O_DONE,
  output logic                  O_TILE_REQ,
  input  logic                  I_TILE_RDY,
  output logic [TILE_CNT_W-1:0] O_TILE_M,
  output logic [TILE_CNT_W-1:0] O_TILE_N,
  output logic [TILE_CNT_W-1:0] O_TILE_K,
  output logic                  O_SA_LOAD,
  input  logic                  I_SA_OUT_VLD,
  output logic                  O_RES_VLD,
  input  logic                  I_RES_RDY,
  output logic                  O_RES_LAST_K,
  output logic                  O_TIMEOUT_ERR
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LOAD,
    ST_RUN,
    ST_RESULT,
    ST_DONE
  } state_t;

  localparam logic [TILE_CNT_W-1:0] CNT_ONE  = TILE_CNT_W'(1);
  localparam logic [TILE_CNT_W-1:0] CNT_ZERO = '0;

  state_t                  state_q, state_d;
  logic [TILE_CNT_W-1:0]   m_cnt_q, m_cnt_d;
  logic [TILE_CNT_W-1:0]   n_cnt_q, n_cnt_d;
  logic [TILE_CNT_W-1:0]   k_cnt_q, k_cnt_d;
  logic [TILE_CNT_W-1:0]   m_idx_q, m_idx_d;
  logic [TILE_CNT_W-1:0]   n_idx_q, n_idx_d;
  logic [TILE_CNT_W-1:0]   k_idx_q, k_idx_d;
  logic                    m_last, n_last, k_last;
  logic                    to_fire;

  assign m_last = (m_idx_q == m_cnt_q - CNT_ONE);
  assign n_last = (n_idx_q == n_cnt_q - CNT_ONE);
  assign k_last = (k_idx_q == k_cnt_q - CNT_ONE);

`ifdef SA_SCHED_TIMEOUT_EN
  localparam int              TO_W     = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_CYC - 1);

  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            to_err_q, to_err_d;

  // Fires on the TIMEOUT_CYC-th RUN cycle, counted from RUN entry.
  assign to_fire = (to_cnt_q == TO_LIMIT);

  always_ff @(posedge I_CLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      to_cnt_q <= '0;
      to_err_q <= 1'b0;
    end else begin
      to_cnt_q <= to_cnt_d;
      to_err_q <= to_err_d;
    end
  end

  always_comb begin
    to_cnt_d = to_cnt_q;
    to_err_d = to_err_q;
    if (state_q == ST_IDLE && I_START) begin
      to_err_d = 1'b0;
    end
    if (state_q == ST_LOAD) begin
      to_cnt_d = '0;
    end else if (state_q == ST_RUN) begin
      to_cnt_d = to_cnt_q + TO_W'(1);
      if (!I_SA_OUT_VLD && to_fire) begin
        to_err_d = 1'b1;
      end
    end
  end

  assign O_TIMEOUT_ERR = to_err_q;
`else
  assign to_fire       = 1'b0;
  assign O_TIMEOUT_ERR = 1'b0;
`endif

  always_ff @(posedge I_CLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      state_q <= ST_IDLE;
      m_cnt_q <= '0;
      n_cnt_q <= '0;
      k_cnt_q <= '0;
      m_idx_q <= '0;
      n_idx_q <= '0;
      k_idx_q <= '0;
    end else begin
      state_q <= state_d;
      m_cnt_q <= m_cnt_d;
      n_cnt_q <= n_cnt_d;
      k_cnt_q <= k_cnt_d;
      m_idx_q <= m_idx_d;
      n_idx_q <= n_idx_d;
      k_idx_q <= k_idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    m_cnt_d = m_cnt_q;
    n_cnt_d = n_cnt_q;
    k_cnt_d = k_cnt_q;
    m_idx_d = m_idx_q;
    n_idx_d = n_idx_q;
    k_idx_d = k_idx_q;
    unique case (state_q)
      ST_IDLE: begin
        if (I_START) begin
          m_cnt_d = I_M_TILES;
          n_cnt_d = I_N_TILES;
          k_cnt_d = I_K_TILES;
          m_idx_d = '0;
          n_idx_d = '0;
          k_idx_d = '0;
          if (I_M_TILES == CNT_ZERO || I_N_TILES == CNT_ZERO || I_K_TILES == CNT_ZERO) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_FETCH;
          end
        end
      end
      ST_FETCH: begin
        if (I_TILE_RDY) begin
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (I_SA_OUT_VLD) begin
          state_d = ST_RESULT;
        end else if (to_fire) begin
          state_d = ST_DONE;
        end
      end
      ST_RESULT: begin
        // Indices only move on the handshake so they stay stable under backpressure.
        if (I_RES_RDY) begin
          k_idx_d = k_last ? CNT_ZERO : k_idx_q + CNT_ONE;
          if (k_last) begin
            n_idx_d = n_last ? CNT_ZERO : n_idx_q + CNT_ONE;
          end
          if (k_last && n_last) begin
            m_idx_d = m_last ? CNT_ZERO : m_idx_q + CNT_ONE;
          end
          state_d = (k_last && n_last && m_last) ? ST_DONE : ST_FETCH;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign O_BUSY       = (state_q != ST_IDLE);
  assign O_DONE       = (state_q == ST_DONE);
  assign O_TILE_REQ   = (state_q == ST_FETCH);
  assign O_SA_LOAD    = (state_q == ST_LOAD);
  assign O_RES_VLD    = (state_q == ST_RESULT);
  assign O_RES_LAST_K = (state_q == ST_RESULT) && k_last;
  assign O_TILE_M     = m_idx_q;
  assign O_TILE_N     = n_idx_q;
  assign O_TILE_K     = k_idx_q;

endmodule

// File: tb/tb_sa_tile_scheduler.sv
// Scoreboard bench for sa_tile_scheduler: fetcher/array/sink models, expected results queued per job.
module tb_sa_tile_scheduler;
  localparam int W = 8;
`ifdef SA_SCHED_TIMEOUT_EN
  localparam int TO_CYC = 16;
`else
  localparam int TO_CYC = 256;
`endif

  logic         I_CLK = 1'b0;
  logic         I_RST_N = 1'b0;
  logic         I_START = 1'b0;
  logic [W-1:0] I_M_TILES = '0;
  logic [W-1:0] I_N_TILES = '0;
  logic [W-1:0] I_K_TILES = '0;
  logic         I_TILE_RDY = 1'b0;
  logic         I_SA_OUT_VLD = 1'b0;
  logic         I_RES_RDY = 1'b0;
  logic         O_BUSY, O_DONE, O_TILE_REQ, O_SA_LOAD, O_RES_VLD, O_RES_LAST_K, O_TIMEOUT_ERR;
  logic [W-1:0] O_TILE_M, O_TILE_N, O_TILE_K;

  sa_tile_scheduler #(.TILE_CNT_W(W), .TIMEOUT_CYC(TO_CYC)) dut (
    .I_CLK(I_CLK), .I_RST_N(I_RST_N), .I_START(I_START),
    .I_M_TILES(I_M_TILES), .I_N_TILES(I_N_TILES), .I_K_TILES(I_K_TILES),
    .O_BUSY(O_BUSY), .O_DONE(O_DONE), .O_TILE_REQ(O_TILE_REQ), .I_TILE_RDY(I_TILE_RDY),
    .O_TILE_M(O_TILE_M), .O_TILE_N(O_TILE_N), .O_TILE_K(O_TILE_K),
    .O_SA_LOAD(O_SA_LOAD), .I_SA_OUT_VLD(I_SA_OUT_VLD),
    .O_RES_VLD(O_RES_VLD), .I_RES_RDY(I_RES_RDY), .O_RES_LAST_K(O_RES_LAST_K),
    .O_TIMEOUT_ERR(O_TIMEOUT_ERR)
  );

  always #5 I_CLK = ~I_CLK;

  int            errors = 0;
  int            checks = 0;
  logic [3*W:0]  sb_q[$];
  int            load_cnt = 0;
  int            sa_delay = 3;
  bit            sa_en = 1'b1;
  bit            rdy_rand = 1'b0;
  bit            res_rand = 1'b0;
  bit            res_force = 1'b1;

  // Fetcher and downstream sink models; inputs change 1 time unit after the rising edge.
  initial forever begin
    @(posedge I_CLK);
    #1;
    I_TILE_RDY = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    I_RES_RDY  = res_rand ? 1'($urandom_range(0, 1)) : res_force;
  end

  // Array model: output-valid pulse sa_delay cycles after the load cycle.
  initial forever begin
    @(negedge I_CLK);
    if (O_SA_LOAD && sa_en) begin
      repeat (sa_delay) @(posedge I_CLK);
      #1 I_SA_OUT_VLD = 1'b1;
      @(posedge I_CLK);
      #1 I_SA_OUT_VLD = 1'b0;
    end
  end

  // Result monitor: every accepted result is compared against the head of the scoreboard.
  initial forever begin
    logic [3*W:0] got, exp_v;
    @(negedge I_CLK);
    if (O_SA_LOAD) load_cnt++;
    if (O_RES_VLD && I_RES_RDY) begin
      got = {O_TILE_M, O_TILE_N, O_TILE_K, O_RES_LAST_K};
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL result_unexpected got m=%0d n=%0d k=%0d last=%0d required none",
                 O_TILE_M, O_TILE_N, O_TILE_K, O_RES_LAST_K);
      end else begin
        exp_v = sb_q.pop_front();
        if (got !== exp_v) begin
          errors++;
          $display("FAIL result_order got m=%0d n=%0d k=%0d last=%0d required m=%0d n=%0d k=%0d last=%0d",
                   got[3*W:2*W+1], got[2*W:W+1], got[W:1], got[0],
                   exp_v[3*W:2*W+1], exp_v[2*W:W+1], exp_v[W:1], exp_v[0]);
        end else begin
          $display("result m=%0d n=%0d k=%0d last=%0d ok", O_TILE_M, O_TILE_N, O_TILE_K, O_RES_LAST_K);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push_job(input int m, input int n, input int k);
    for (int mi = 0; mi < m; mi++)
      for (int ni = 0; ni < n; ni++)
        for (int ki = 0; ki < k; ki++)
          sb_q.push_back({W'(mi), W'(ni), W'(ki), (ki == k - 1)});
  endtask

  task automatic pulse_start(input int m, input int n, input int k);
    @(posedge I_CLK);
    #1;
    I_M_TILES = W'(m);
    I_N_TILES = W'(n);
    I_K_TILES = W'(k);
    I_START   = 1'b1;
    @(posedge I_CLK);
    #1 I_START = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge I_CLK);
      if (O_DONE) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_load(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge I_CLK);
      if (O_SA_LOAD) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    logic [6:0] flags;
    repeat (3) @(negedge I_CLK);
    flags = {O_BUSY, O_DONE, O_TILE_REQ, O_SA_LOAD, O_RES_VLD, O_RES_LAST_K, O_TIMEOUT_ERR};
    checks++;
    if (flags !== 7'b0) begin
      errors++;
      $display("FAIL reset_flags got %b required 0000000", flags);
    end
    checks++;
    if ({O_TILE_M, O_TILE_N, O_TILE_K} !== '0) begin
      errors++;
      $display("FAIL reset_indices got %0d/%0d/%0d required 0/0/0", O_TILE_M, O_TILE_N, O_TILE_K);
    end
    @(posedge I_CLK);
    #1 I_RST_N = 1'b1;
    $display("reset released");
  endtask

  task automatic test_single_tile();
    bit ok;
    int l0;
    sa_delay = 20; rdy_rand = 1'b0; res_rand = 1'b0; res_force = 1'b1;
    l0 = load_cnt;
    push_job(1, 1, 1);
    pulse_start(1, 1, 1);
    @(negedge I_CLK);
    checks++;
    if (O_TILE_REQ !== 1'b1) begin
      errors++;
      $display("FAIL single_req_cycle1 got %b required 1", O_TILE_REQ);
    end
    @(negedge I_CLK);
    checks++;
    if (O_SA_LOAD !== 1'b1) begin
      errors++;
      $display("FAIL single_load_cycle2 got %b required 1", O_SA_LOAD);
    end
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge I_CLK);
      if (O_RES_VLD && I_RES_RDY) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL single_result_timeout got none required one result");
    end
    @(negedge I_CLK);
    checks++;
    if (O_DONE !== 1'b1) begin
      errors++;
      $display("FAIL single_done_t1 got %b required 1", O_DONE);
    end
    @(negedge I_CLK);
    checks++;
    if (O_BUSY !== 1'b0 || O_DONE !== 1'b0) begin
      errors++;
      $display("FAIL single_idle_t2 got busy=%b done=%b required 0/0", O_BUSY, O_DONE);
    end
    checks++;
    if (load_cnt - l0 != 1 || sb_q.size() != 0) begin
      errors++;
      $display("FAIL single_counts got loads=%0d pending=%0d required 1/0", load_cnt - l0, sb_q.size());
    end
    sa_delay = 3;
    $display("single tile job complete");
  endtask

  task automatic test_order();
    bit ok;
    sa_delay = 2; rdy_rand = 1'b1; res_rand = 1'b1;
    push_job(2, 2, 2);
    pulse_start(2, 2, 2);
    wait_done(2000, ok);
    checks++;
    if (!ok || sb_q.size() != 0) begin
      errors++;
      $display("FAIL order_job got done=%0d pending=%0d required 1/0", ok, sb_q.size());
    end
    rdy_rand = 1'b0; res_rand = 1'b0; res_force = 1'b1; sa_delay = 3;
    @(negedge I_CLK);
    $display("order job complete");
  endtask

  task automatic test_backpressure();
    bit ok;
    int l0;
    logic [3*W-1:0] cap;
    res_rand = 1'b0; res_force = 1'b0;
    push_job(1, 1, 2);
    pulse_start(1, 1, 2);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge I_CLK);
      if (O_RES_VLD) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL bp_vld_timeout got none required O_RES_VLD");
    end
    cap = {O_TILE_M, O_TILE_N, O_TILE_K};
    l0  = load_cnt;
    for (int i = 0; i < 5; i++) begin
      @(negedge I_CLK);
      checks++;
      if ({O_RES_VLD, O_TILE_M, O_TILE_N, O_TILE_K, O_TILE_REQ, O_SA_LOAD} !== {1'b1, cap, 2'b00}) begin
        errors++;
        $display("FAIL bp_hold cycle=%0d got vld=%b idx=%h req=%b load=%b required 1/%h/0/0",
                 i, O_RES_VLD, {O_TILE_M, O_TILE_N, O_TILE_K}, O_TILE_REQ, O_SA_LOAD, cap);
      end
    end
    res_force = 1'b1;
    wait_done(500, ok);
    checks++;
    if (!ok || sb_q.size() != 0 || load_cnt - l0 != 1) begin
      errors++;
      $display("FAIL bp_finish got done=%0d pending=%0d loads=%0d required 1/0/1",
               ok, sb_q.size(), load_cnt - l0);
    end
    @(negedge I_CLK);
    $display("backpressure job complete");
  endtask

  task automatic test_zero_count();
    int l0;
    l0 = load_cnt;
    pulse_start(3, 2, 0);
    @(negedge I_CLK);
    checks++;
    if (O_DONE !== 1'b1 || O_TILE_REQ !== 1'b0 || O_SA_LOAD !== 1'b0) begin
      errors++;
      $display("FAIL zero_done_c1 got done=%b req=%b load=%b required 1/0/0", O_DONE, O_TILE_REQ, O_SA_LOAD);
    end
    @(negedge I_CLK);
    checks++;
    if (O_BUSY !== 1'b0 || O_DONE !== 1'b0 || load_cnt != l0) begin
      errors++;
      $display("FAIL zero_idle_c2 got busy=%b done=%b loads=%0d required 0/0/0", O_BUSY, O_DONE, load_cnt - l0);
    end
    $display("zero count job complete");
  endtask

  task automatic test_start_while_busy();
    bit ok;
    int l0;
    l0 = load_cnt;
    push_job(1, 1, 2);
    pulse_start(1, 1, 2);
    wait_load(100, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL busy_first_load got none required O_SA_LOAD");
    end
    pulse_start(3, 3, 3);
    wait_done(500, ok);
    checks++;
    if (!ok || sb_q.size() != 0 || load_cnt - l0 != 2) begin
      errors++;
      $display("FAIL busy_restart got done=%0d pending=%0d loads=%0d required 1/0/2",
               ok, sb_q.size(), load_cnt - l0);
    end
    repeat (3) @(negedge I_CLK);
    checks++;
    if (O_BUSY !== 1'b0) begin
      errors++;
      $display("FAIL busy_after_done got %b required 0", O_BUSY);
    end
    $display("start while busy job complete");
  endtask

  task automatic test_reset_mid_job();
    bit ok;
    bit saw_done;
    pulse_start(2, 2, 2);
    wait_load(100, ok);
    #2 I_RST_N = 1'b0;
    #1;
    checks++;
    if (!ok || O_BUSY !== 1'b0 || O_SA_LOAD !== 1'b0) begin
      errors++;
      $display("FAIL midreset_async got load_seen=%0d busy=%b load=%b required 1/0/0", ok, O_BUSY, O_SA_LOAD);
    end
    saw_done = 1'b0;
    repeat (3) begin
      @(negedge I_CLK);
      saw_done |= O_DONE;
    end
    @(posedge I_CLK);
    #1 I_RST_N = 1'b1;
    repeat (10) begin
      @(negedge I_CLK);
      saw_done |= O_DONE;
    end
    checks++;
    if (saw_done !== 1'b0 || O_BUSY !== 1'b0) begin
      errors++;
      $display("FAIL midreset_no_done got done_seen=%b busy=%b required 0/0", saw_done, O_BUSY);
    end
    $display("mid-job reset complete");
  endtask

`ifdef SA_SCHED_TIMEOUT_EN
  task automatic test_timeout();
    bit ok;
    sa_en = 1'b0;
    pulse_start(1, 1, 1);
    wait_load(100, ok);
    repeat (TO_CYC) @(negedge I_CLK);
    checks++;
    if (!ok || O_DONE !== 1'b0) begin
      errors++;
      $display("FAIL timeout_early got load_seen=%0d done=%b required 1/0", ok, O_DONE);
    end
    @(negedge I_CLK);
    checks++;
    if (O_DONE !== 1'b1 || O_TIMEOUT_ERR !== 1'b1 || O_RES_VLD !== 1'b0) begin
      errors++;
      $display("FAIL timeout_fire got done=%b err=%b vld=%b required 1/1/0", O_DONE, O_TIMEOUT_ERR, O_RES_VLD);
    end
    repeat (2) @(negedge I_CLK);
    sa_en = 1'b1;
    push_job(1, 1, 1);
    pulse_start(1, 1, 1);
    @(negedge I_CLK);
    checks++;
    if (O_TIMEOUT_ERR !== 1'b0) begin
      errors++;
      $display("FAIL timeout_clear got %b required 0", O_TIMEOUT_ERR);
    end
    wait_done(500, ok);
    checks++;
    if (!ok || sb_q.size() != 0) begin
      errors++;
      $display("FAIL timeout_next_job got done=%0d pending=%0d required 1/0", ok, sb_q.size());
    end
    @(negedge I_CLK);
    $display("timeout scenario complete");
  endtask
`endif

  initial begin
    test_reset();
    test_single_tile();
    test_order();
    test_backpressure();
    test_zero_count();
    test_start_while_busy();
    test_reset_mid_job();
`ifdef SA_SCHED_TIMEOUT_EN
    test_timeout();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
